// File: rtl/convolution_processor_pkg.sv
// Shared types and width defaults for the convolution processor datapath.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package convolution_processor_pkg;

  // Default operand and accumulator widths. The downstream subtractor uses
  // the same constants so both stages agree on the accumulated term width.
  localparam int CP_DATA_WIDTH = 16;
  localparam int CP_ACC_WIDTH  = 40;
  localparam int CP_LEN_WIDTH  = 8;

  // MAC control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_e;

  // Two's-complement addition overflows when both addends share a sign and
  // the sum's sign differs from it. Only the three sign bits are needed.
  function automatic logic add_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/convolution_processor_mult.sv
// Signed DATA_WIDTH x DATA_WIDTH multiplier, full-precision 2*DATA_WIDTH product.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns all handshaking.
module convolution_processor_mult
  import convolution_processor_pkg::*;
#(
  parameter int DATA_WIDTH = CP_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0]   op_a,
  input  logic signed [DATA_WIDTH-1:0]   op_b,
  output logic signed [2*DATA_WIDTH-1:0] prod
);

  // Both operands are signed, so they are sign-extended to the 2*DATA_WIDTH
  // result width before multiplying; the product never truncates.
  assign prod = op_a * op_b;

endmodule

// File: rtl/convolution_processor_mac.sv
// Sequential signed MAC: accumulates a run of len products into one dot-product term.
// Latency: 1 cycle from the last accepted pair to out_valid; 1 pair per cycle throughput.
// Backpressure: in_ready only in ACCUM; result/ovf held in DONE until out_ready.
module convolution_processor_mac
  import convolution_processor_pkg::*;
#(
  parameter int DATA_WIDTH = CP_DATA_WIDTH,
  parameter int ACC_WIDTH  = CP_ACC_WIDTH,
  parameter int LEN_WIDTH  = CP_LEN_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_b,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [ACC_WIDTH-1:0]  result,
  output logic                         ovf,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  mac_state_e                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] result_q, result_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic                        ovf_q, ovf_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    sum;
  logic                           sum_ovf;
  logic                           last_pair;

  // Multiplier kept in its own module so a pipelined/DSP version can drop in.
  convolution_processor_mult #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .op_a (in_a),
    .op_b (in_b),
    .prod (prod)
  );

  // Sign-extend the product to accumulator width; the sum wraps modulo 2^ACC_WIDTH.
  always_comb begin
    prod_ext  = ACC_WIDTH'(prod);
    sum       = acc_q + prod_ext;
    sum_ovf   = add_ovf(acc_q[ACC_WIDTH-1], prod_ext[ACC_WIDTH-1], sum[ACC_WIDTH-1]);
    last_pair = (cnt_q == (len_q - LEN_WIDTH'(1)));
  end

  // Handshake and status outputs depend on state alone, so they never glitch on inputs.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    result    = result_q;
    ovf       = ovf_q;
  end

  // Next-state and datapath update; start is only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (len != '0) begin
            len_d   = len;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            // Empty run: report a zero term straight away.
            result_d = '0;
            state_d  = DONE;
          end
        end
      end

      ACCUM: begin
        // in_ready is 1 throughout ACCUM, so in_valid alone marks an accept.
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (sum_ovf) begin
            ovf_d = 1'b1;
          end
          if (last_pair) begin
            result_d = sum;
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; asynchronous reset drops any partial run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
